// File: rtl/gf_reduce_seq.sv
// gf_reduce_seq
//   Bit-serial reduction of a carry-less (GF(2)) product modulo the
//   irreducible trinomial f(x) = x^M + x^K + 1. One high-order coefficient
//   is folded per cycle, from x^(2M-2) down to x^M, so a result is ready
//   M-1 cycles after the operand is accepted.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   p          (2M-1)-bit product, bit i = coefficient of x^i
//   in_valid   p is valid (sampled only when in_ready=1)
//   in_ready   block is idle and can accept p
//   y          M-bit remainder p mod f(x)
//   out_valid  y is valid; held until out_ready=1
//   out_ready  consumer accepts y
//   busy       reduction in progress
module gf_reduce_seq #(
  parameter int M = 93,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [2*M-2:0] p,
  input  logic           in_valid,
  output logic           in_ready,
  output logic [M-1:0]   y,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           busy
);

  localparam int AW    = 2 * M - 1;
  localparam int IDX_W = $clog2(2 * M - 1);

  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(2 * M - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(M);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;

  // One fold step: x^i == x^(i-M+K) + x^(i-M) (mod f), so a set bit i is
  // cleared and its two images toggled. Both images lie strictly below i,
  // and any image still at or above M is folded on a later step.
  function automatic logic [AW-1:0] reduce_step(
    input logic [AW-1:0]    acc,
    input logic [IDX_W-1:0] idx
  );
    logic [AW-1:0]    one;
    logic [IDX_W-1:0] lo;
    logic [IDX_W-1:0] mid;
    one = AW'(1);
    lo  = idx - IDX_W'(M);
    mid = lo + IDX_W'(K);
    reduce_step = acc;
    if (acc[idx]) begin
      reduce_step = acc ^ (one << idx) ^ (one << mid) ^ (one << lo);
    end
  endfunction

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          acc_d   = p;
          idx_d   = IDX_TOP;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d = reduce_step(acc_q, idx_q);
        // The x^M step is the last fold; the index parks at M rather than
        // stepping below it.
        if (idx_q == IDX_LAST) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the next-state decode.
    in_ready_d  = (state_d == IDLE);
    busy_d      = (state_d == BUSY);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign y         = acc_q[M-1:0];

endmodule

// File: tb/tb_gf_reduce_seq.sv
// tb_gf_reduce_seq
//   Directed bench for gf_reduce_seq at M=93, K=2. Expected remainders come
//   from a long-division reference and travel through a scoreboard queue
//   from the acceptance point to the output handshake.
module tb_gf_reduce_seq;

  localparam int M  = 93;
  localparam int K  = 2;
  localparam int AW = 2 * M - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] p = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [M-1:0]  y;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;

  logic [M-1:0]  exp_q[$];
  int            n_vec = 0;
  int            n_err = 0;

  always #5 clk = ~clk;

  gf_reduce_seq #(.M(M), .K(K)) dut (
    .clk      (clk),
    .rst      (rst),
    .p        (p),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy)
  );

  // Reference: schoolbook long division by f(x), highest term first.
  function automatic logic [M-1:0] gf_mod(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    logic [AW-1:0] f;
    r    = a;
    f    = '0;
    f[M] = 1'b1;
    f[K] = 1'b1;
    f[0] = 1'b1;
    for (int i = AW - 1; i >= M; i--) begin
      if (r[i]) r = r ^ (f << (i - M));
    end
    return r[M-1:0];
  endfunction

  function automatic logic [AW-1:0] rnd_p();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[AW-1:0];
  endfunction

  task automatic chk_b(input string tag, input logic obs, input logic expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic chk_y(input string tag, input logic [M-1:0] obs, input logic [M-1:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 10) begin
      tick();
      n++;
    end
    chk_b({tag, "_ready_wait"}, in_ready, 1'b1);
  endtask

  // Accept pv, wait for the result, optionally stall in DONE for `hold`
  // cycles while poking in_valid, then complete the output handshake.
  task automatic run_op(input string tag, input logic [AW-1:0] pv,
                        input bit rdy_early, input int hold,
                        output logic [M-1:0] yo);
    int           lat;
    logic [M-1:0] held;
    logic [M-1:0] e;
    wait_ready(tag);
    out_ready = rdy_early;
    p         = pv;
    in_valid  = 1'b1;
    exp_q.push_back(gf_mod(pv));
    tick();
    in_valid = 1'b0;
    p        = rnd_p();
    chk_b({tag, "_busy"}, busy, 1'b1);
    chk_b({tag, "_in_ready_busy"}, in_ready, 1'b0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk_i({tag, "_latency"}, lat, M - 1);
    held = y;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1 & $urandom_range(0, 1);
      p        = rnd_p();
      tick();
      chk_y({tag, "_hold_y"}, y, held);
      chk_b({tag, "_hold_ov"}, out_valid, 1'b1);
      chk_b({tag, "_hold_ir"}, in_ready, 1'b0);
    end
    in_valid = 1'b0;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
    yo = y;
    chk_y({tag, "_y"}, y, e);
    out_ready = 1'b1;
    tick();
    chk_b({tag, "_ov_after_hs"}, out_valid, 1'b0);
    chk_b({tag, "_ir_after_hs"}, in_ready, 1'b1);
    out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [M-1:0]  yv;
    logic [M-1:0]  ye;
    logic [AW-1:0] pv;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_b("rst_in_ready", in_ready, 1'b1);
    chk_b("rst_busy", busy, 1'b0);
    chk_b("rst_out_valid", out_valid, 1'b0);
    chk_y("rst_y", y, '0);
    @(negedge clk);
    rst = 1'b0;

    // Zero operand, consumer always ready
    run_op("zero", '0, 1'b1, 0, yv);
    chk_y("zero_const", yv, '0);

    // x^93 -> x^2 + 1
    pv = '0;
    pv[93] = 1'b1;
    run_op("x93", pv, 1'b0, 0, yv);
    chk_y("x93_const", yv, M'(5));

    // x^184 -> x^91 + x^2 + 1
    pv = '0;
    pv[184] = 1'b1;
    run_op("x184", pv, 1'b0, 0, yv);
    ye = '0;
    ye[91] = 1'b1;
    ye[2]  = 1'b1;
    ye[0]  = 1'b1;
    chk_y("x184_const", yv, ye);

    // Operand already below x^M passes through unchanged
    pv = AW'(64'h1234_5678_9ABC_DEF0);
    run_op("low", pv, 1'b0, 0, yv);
    chk_y("low_const", yv, M'(64'h1234_5678_9ABC_DEF0));

    // Random operand with a 20-cycle consumer stall
    run_op("stall", rnd_p(), 1'b0, 20, yv);

    // A few more random operands, back to back
    for (int i = 0; i < 3; i++) begin
      run_op("rand", rnd_p(), 1'b0, 0, yv);
    end

    // Asynchronous reset in the middle of BUSY
    wait_ready("abort");
    p        = rnd_p();
    in_valid = 1'b1;
    exp_q.push_back(gf_mod(p));
    tick();
    in_valid = 1'b0;
    repeat (39) tick();
    chk_b("abort_busy_before", busy, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk_b("abort_out_valid", out_valid, 1'b0);
    chk_b("abort_busy", busy, 1'b0);
    chk_b("abort_in_ready", in_ready, 1'b1);
    chk_y("abort_y", y, '0);
    exp_q.delete();
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_y("abort_y_after_release", y, '0);
    run_op("post_rst", rnd_p(), 1'b0, 0, yv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
